// File: rtl/hub_linear_fold_ctrl_if.sv
// Scheduler-side handshake and layer-control bundle of the folded linear
// layer frame sequencer. The master is the layer scheduler / control
// consumer; the slave is the sequencer itself.
interface hub_linear_fold_ctrl_if #(
  parameter int PWID = 1
);
  logic            iStart;
  logic            iNewWgt;
  logic            oReady;
  logic            oLoad;
  logic            oSel;
  logic            oClear;
  logic [PWID-1:0] oPart;
  logic            oBusy;
  logic            oDone;

  modport master (
    output iStart,
    output iNewWgt,
    input  oReady,
    input  oLoad,
    input  oSel,
    input  oClear,
    input  oPart,
    input  oBusy,
    input  oDone
  );

  modport slave (
    input  iStart,
    input  iNewWgt,
    output oReady,
    output oLoad,
    output oSel,
    output oClear,
    output oPart,
    output oBusy,
    output oDone
  );
endinterface

// File: rtl/hub_linear_fold_ctrl.sv
// Frame sequencer for the folded hybrid unary-binary linear layer.
// One accepted start produces: optional weight load, one clear cycle,
// FOLD partitions of SLEN stream cycles, LAT drain cycles, one done pulse.
// The accumulate-side select flips at every clear so the previous frame's
// result stays readable on the other buffer side.
module hub_linear_fold_ctrl #(
  parameter int FOLD = 1,
  parameter int PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
  parameter int SLEN = 256,
  parameter int CWID = ($clog2(SLEN) < 1) ? 1 : $clog2(SLEN),
  parameter int LAT  = 2,
  parameter int LWID = ($clog2(LAT + 1) < 1) ? 1 : $clog2(LAT + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  hub_linear_fold_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Terminal counts; the drain terminal is unreachable when LAT = 0.
  localparam logic [CWID-1:0] CNT_LAST  = CWID'(SLEN - 1);
  localparam logic [PWID-1:0] PART_LAST = PWID'(FOLD - 1);
  localparam logic [LWID-1:0] DRN_LAST  = LWID'((LAT == 0) ? 0 : LAT - 1);

  state_e          state_q, state_d;
  logic [CWID-1:0] cnt_q, cnt_d;
  logic [PWID-1:0] part_q, part_d;
  logic [LWID-1:0] drn_q, drn_d;
  logic            sel_q, sel_d;

  logic            lastCycle;
  logic            lastPart;
  logic            lastDrain;
  logic            enterClear;

  logic            readyO;
  logic            loadO;
  logic            clearO;
  logic            busyO;
  logic            doneO;

  assign lastCycle  = (cnt_q == CNT_LAST);
  assign lastPart   = (part_q == PART_LAST);
  assign lastDrain  = (drn_q == DRN_LAST);
  assign enterClear = (state_d == CLEAR) && (state_q != CLEAR);

  // State register; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE, so there is no queue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d = bus.iNewWgt ? LOAD : CLEAR;
        end
      end
      LOAD:  state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN: begin
        if (lastCycle && lastPart) begin
          state_d = (LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (lastDrain) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and buffer-select registers, cleared with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      part_q <= '0;
      drn_q  <= '0;
      sel_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
      drn_q  <= drn_d;
      sel_q  <= sel_d;
    end
  end

  // Stream/partition/drain stepping; partition holds its last value through
  // drain and done, and everything returns to zero on the way back to IDLE.
  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    drn_d  = drn_q;
    sel_d  = sel_q;

    if (enterClear) begin
      sel_d = ~sel_q;
    end

    case (state_q)
      RUN: begin
        if (lastCycle) begin
          cnt_d = '0;
          if (!lastPart) begin
            part_d = part_q + PWID'(1);
          end
        end else begin
          cnt_d = cnt_q + CWID'(1);
        end
      end
      DRAIN: begin
        drn_d = lastDrain ? '0 : drn_q + LWID'(1);
      end
      default: begin
      end
    endcase

    if (state_d == IDLE) begin
      cnt_d  = '0;
      part_d = '0;
      drn_d  = '0;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    readyO = 1'b0;
    loadO  = 1'b0;
    clearO = 1'b0;
    busyO  = 1'b1;
    doneO  = 1'b0;
    case (state_q)
      IDLE: begin
        readyO = 1'b1;
        busyO  = 1'b0;
      end
      LOAD:    loadO  = 1'b1;
      CLEAR:   clearO = 1'b1;
      DONE:    doneO  = 1'b1;
      default: begin
      end
    endcase
  end

  assign bus.oReady = readyO;
  assign bus.oBusy  = busyO;
  assign bus.oLoad  = loadO;
  assign bus.oClear = clearO;
  assign bus.oDone  = doneO;
  assign bus.oSel   = sel_q;
  assign bus.oPart  = part_q;

endmodule

// File: tb/tb_hub_linear_fold_ctrl.sv
// Directed bench for the folded-layer frame sequencer. Four instances with
// different FOLD/SLEN/LAT share clock and reset; one is exercised at a time.
// Expected per-cycle output vectors come from the frame timeline formulas
// and are queued when a start is driven, then popped each cycle.
module tb_hub_linear_fold_ctrl;

  logic clk;
  logic rst_n;

  // Observed vector layout: {ready, busy, load, clear, sel, done, part[1:0]}
  logic       start  [4];
  logic       newWgt [4];
  logic [7:0] obs    [4];

  int cfgFold [4] = '{1, 4, 3, 2};
  int cfgSlen [4] = '{4, 8, 1, 4};
  int cfgLat  [4] = '{2, 0, 1, 2};

  logic       selExp [4];
  logic [7:0] sbQ [$];
  int         errors = 0;
  int         checks = 0;

  localparam logic [7:0] RESET_VEC = 8'b1000_0000;

  hub_linear_fold_ctrl_if #(.PWID(1)) ifA ();
  hub_linear_fold_ctrl_if #(.PWID(2)) ifB ();
  hub_linear_fold_ctrl_if #(.PWID(2)) ifC ();
  hub_linear_fold_ctrl_if #(.PWID(1)) ifD ();

  hub_linear_fold_ctrl #(.FOLD(1), .SLEN(4), .LAT(2)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  hub_linear_fold_ctrl #(.FOLD(4), .SLEN(8), .LAT(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  hub_linear_fold_ctrl #(.FOLD(3), .SLEN(1), .LAT(1)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));
  hub_linear_fold_ctrl #(.FOLD(2), .SLEN(4), .LAT(2)) dutD (.clk(clk), .rst_n(rst_n), .bus(ifD));

  assign ifA.iStart = start[0];
  assign ifB.iStart = start[1];
  assign ifC.iStart = start[2];
  assign ifD.iStart = start[3];
  assign ifA.iNewWgt = newWgt[0];
  assign ifB.iNewWgt = newWgt[1];
  assign ifC.iNewWgt = newWgt[2];
  assign ifD.iNewWgt = newWgt[3];

  assign obs[0] = {ifA.oReady, ifA.oBusy, ifA.oLoad, ifA.oClear, ifA.oSel, ifA.oDone, 1'b0, ifA.oPart};
  assign obs[1] = {ifB.oReady, ifB.oBusy, ifB.oLoad, ifB.oClear, ifB.oSel, ifB.oDone, ifB.oPart};
  assign obs[2] = {ifC.oReady, ifC.oBusy, ifC.oLoad, ifC.oClear, ifC.oSel, ifC.oDone, ifC.oPart};
  assign obs[3] = {ifD.oReady, ifD.oBusy, ifD.oLoad, ifD.oClear, ifD.oSel, ifD.oDone, 1'b0, ifD.oPart};

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t cycles after the accepting edge, from the frame timeline.
  function automatic logic [7:0] expVec(input int f, input int s, input int l,
                                        input int ld, input int t,
                                        input logic oldSel, input logic newSel);
    int c;
    logic [1:0] p;
    c = t - ld;
    if (ld == 1 && t == 1) return {1'b0, 1'b1, 1'b1, 1'b0, oldSel, 1'b0, 2'd0};
    if (c == 1)            return {1'b0, 1'b1, 1'b0, 1'b1, newSel, 1'b0, 2'd0};
    if (c >= 2 && c <= f * s + 1) begin
      p = 2'((c - 2) / s);
      return {1'b0, 1'b1, 1'b0, 1'b0, newSel, 1'b0, p};
    end
    p = 2'(f - 1);
    if (c <= f * s + l + 1) return {1'b0, 1'b1, 1'b0, 1'b0, newSel, 1'b0, p};
    if (c == f * s + l + 2) return {1'b0, 1'b1, 1'b0, 1'b0, newSel, 1'b1, p};
    return {1'b1, 1'b0, 1'b0, 1'b0, newSel, 1'b0, 2'd0};
  endfunction

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Hold reset for a few cycles and check every instance sits at reset values.
  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("reset dut%0d", i), obs[i], RESET_VEC);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) selExp[i] = 1'b0;
  endtask

  // Drive one frame request on instance d from an IDLE negedge and check each
  // cycle through the first IDLE cycle afterwards. hold keeps iStart high the
  // whole frame; abortAt > 0 asserts reset mid-cycle at that frame cycle.
  task automatic applyStimulus(input int d, input int ld, input bit hold, input int abortAt);
    int f, s, l, n;
    logic oldSel, newSel;
    logic [7:0] want;
    f = cfgFold[d];
    s = cfgSlen[d];
    l = cfgLat[d];
    n = f * s + l + 3 + ld;
    oldSel = selExp[d];
    newSel = ~oldSel;
    selExp[d] = newSel;
    start[d]  = 1'b1;
    newWgt[d] = ld[0];
    for (int t = 1; t <= n; t++) sbQ.push_back(expVec(f, s, l, ld, t, oldSel, newSel));
    @(posedge clk);
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      if (!hold) start[d] = 1'b0;
      newWgt[d] = 1'($urandom_range(0, 1));
      want = sbQ.pop_front();
      checkOutput($sformatf("dut%0d cyc%0d", d, t), obs[d], want);
      if (t == abortAt) begin
        #2 rst_n = 1'b0;
        #1 checkOutput($sformatf("dut%0d async reset", d), obs[d], RESET_VEC);
        checkOutput("other dut during reset", obs[0], RESET_VEC);
        start[d] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput($sformatf("dut%0d held in reset", d), obs[d], RESET_VEC);
        end
        rst_n = 1'b1;
        sbQ.delete();
        for (int i = 0; i < 4; i++) selExp[i] = 1'b0;
        return;
      end
    end
  endtask

  // Directed sequence.
  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i]  = 1'b0;
      newWgt[i] = 1'b0;
      selExp[i] = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    applyReset();
    @(negedge clk);

    // FOLD=1 SLEN=4 LAT=2: plain frame, then a frame with weight load.
    applyStimulus(0, 0, 1'b0, 0);
    applyStimulus(0, 1, 1'b0, 0);
    @(negedge clk);

    // Start held high: three frames back-to-back, request ignored mid-frame.
    applyStimulus(0, 0, 1'b1, 0);
    applyStimulus(0, 0, 1'b1, 0);
    applyStimulus(0, 1, 1'b1, 0);
    start[0] = 1'b0;
    @(negedge clk);
    checkOutput("dut0 idle after held start", obs[0], {1'b1, 1'b0, 1'b0, 1'b0, selExp[0], 1'b0, 2'd0});

    // FOLD=4 SLEN=8 LAT=0: load frame then plain frame.
    applyStimulus(1, 1, 1'b0, 0);
    applyStimulus(1, 0, 1'b0, 0);

    // FOLD=3 SLEN=1 LAT=1.
    applyStimulus(2, 0, 1'b0, 0);

    // FOLD=2 SLEN=4 LAT=2: reset inside partition 1, then a normal frame.
    applyStimulus(3, 0, 1'b0, 7);
    applyStimulus(3, 1, 1'b0, 0);
    applyStimulus(3, 0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
